dac_sample_shaper: RTL and testbench



---
 rtl/dac_sample_shaper_pkg.sv | 17 +
 rtl/dac_scale_sat.sv | 102 ++++++++++
 rtl/dac_sample_shaper.sv | 145 ++++++++++++++
 tb/tb_dac_sample_shaper.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_sample_shaper_pkg.sv
// Shared constants and helpers for the DAC sample shaping path feeding the
// LTC1668 serializer (16-bit straight binary).
package dac_sample_shaper_pkg;

    localparam int                  DAC_DATA_WIDTH = 16;
    localparam logic [15:0]         DAC_MIDSCALE   = 16'h8000;
    localparam logic [15:0]         DAC_GAIN_ONE   = 16'h8000;
    localparam int                  GAIN_FRAC_BITS = 15;

    // Two's-complement to offset-binary: flipping the MSB re-centres on midscale.
    function automatic logic [DAC_DATA_WIDTH-1:0] to_offset_binary(
        input logic [DAC_DATA_WIDTH-1:0] twos
    );
        return twos ^ DAC_MIDSCALE;
    endfunction

endpackage

// File: rtl/dac_scale_sat.sv
// Two-stage gain/offset/saturate pipeline producing an offset-binary DAC code.
// Input registers load on the sample tick; the code settles two edges later.
module dac_scale_sat
    import dac_sample_shaper_pkg::*;
#(
    parameter int IN_WIDTH = 18
) (
    input  logic                          clock_i,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          flush,
    input  logic                          live,
    input  logic signed [IN_WIDTH-1:0]    sample,
    input  logic [15:0]                   gain,
    input  logic signed [15:0]            offset,
    output logic [DAC_DATA_WIDTH-1:0]     code,
    output logic                          sat_pulse
);

    localparam int PROD_W = IN_WIDTH + 17;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32'sd32767);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32'sd32768);

    logic signed [IN_WIDTH-1:0] in_sample_r;
    logic [15:0]                in_gain_r;
    logic signed [15:0]         in_offset_r;
    logic                       in_live_r;
    logic                       in_vld_r;
    logic signed [PROD_W-1:0]   prod_r;
    logic signed [15:0]         off1_r;
    logic                       live1_r;
    logic                       vld1_r;
    logic [15:0]                code_r;
    logic                       sat_r;

    logic signed [PROD_W-1:0]   mul_a_s;
    logic signed [PROD_W-1:0]   mul_b_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [PROD_W-1:0]   scaled_s;
    logic signed [SUM_W-1:0]    sum_s;
    logic [15:0]                clip_s;
    logic                       over_s;

    // Multiply, floor-shift, offset and clip arithmetic.
    always_comb begin
        mul_a_s  = PROD_W'(in_sample_r);
        mul_b_s  = PROD_W'({1'b0, in_gain_r});
        prod_s   = mul_a_s * mul_b_s;
        scaled_s = prod_r >>> GAIN_FRAC_BITS;
        sum_s    = SUM_W'(scaled_s) + SUM_W'(off1_r);
        if (sum_s > SAT_MAX) begin
            clip_s = 16'h7FFF;
            over_s = 1'b1;
        end else if (sum_s < SAT_MIN) begin
            clip_s = 16'h8000;
            over_s = 1'b1;
        end else begin
            clip_s = sum_s[15:0];
            over_s = 1'b0;
        end
    end

    // Pipeline registers; a non-live entry (nothing consumed yet) yields midscale.
    always_ff @(posedge clock_i) begin
        if (reset || flush) begin
            in_sample_r <= '0;
            in_gain_r   <= 16'h0000;
            in_offset_r <= 16'sh0000;
            in_live_r   <= 1'b0;
            in_vld_r    <= 1'b0;
            prod_r      <= '0;
            off1_r      <= 16'sh0000;
            live1_r     <= 1'b0;
            vld1_r      <= 1'b0;
            code_r      <= DAC_MIDSCALE;
            sat_r       <= 1'b0;
        end else begin
            in_vld_r <= load;
            if (load) begin
                in_sample_r <= sample;
                in_gain_r   <= gain;
                in_offset_r <= offset;
                in_live_r   <= live;
            end
            vld1_r <= in_vld_r;
            if (in_vld_r) begin
                prod_r  <= prod_s;
                off1_r  <= in_offset_r;
                live1_r <= in_live_r;
            end
            sat_r <= vld1_r & live1_r & over_s;
            if (vld1_r) begin
                code_r <= live1_r ? to_offset_binary(clip_s) : DAC_MIDSCALE;
            end
        end
    end

    assign code      = code_r;
    assign sat_pulse = sat_r;

endmodule

// File: rtl/dac_sample_shaper.sv
// Paces signed samples into the DAC at clock_i/CLK_DIV: one-deep hold register,
// gain/offset/saturation pipeline, data_clock_n strobe and underrun/sat status.
module dac_sample_shaper
    import dac_sample_shaper_pkg::*;
#(
    parameter int CLK_DIV  = 50,
    parameter int IN_WIDTH = 18
) (
    input  logic                          clock_i,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic signed [IN_WIDTH-1:0]    s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [15:0]                   gain_i,
    input  logic signed [15:0]            offset_i,
    input  logic                          clear_i,
    output logic [DAC_DATA_WIDTH-1:0]     data_o,
    output logic                          data_clock_n,
    output logic [15:0]                   underrun_cnt_o,
    output logic                          sat_o
);

    localparam int              PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]   PHASE_FALL = PW'(CLK_DIV / 2 - 1);
    localparam logic [PW-1:0]   PHASE_ONE  = PW'(1);

    logic [PW-1:0]              phase_r;
    logic                       hold_full_r;
    logic signed [IN_WIDTH-1:0] hold_data_r;
    logic signed [IN_WIDTH-1:0] last_r;
    logic                       primed_r;
    logic [15:0]                data_r;
    logic                       dclk_n_r;
    logic [15:0]                underrun_r;
    logic                       sat_r;

    logic                       tick_s;
    logic                       ready_s;
    logic                       accept_s;
    logic                       load_s;
    logic                       flush_s;
    logic                       underrun_s;
    logic signed [IN_WIDTH-1:0] feed_data_s;
    logic                       feed_live_s;
    logic [15:0]                code_s;
    logic                       sat_pulse_s;

    // Tick, handshake and the value handed to the pipeline on each tick.
    always_comb begin
        tick_s      = (phase_r == PHASE_LAST);
        ready_s     = enable_i & ~reset & (~hold_full_r | tick_s);
        accept_s    = s_valid_i & ready_s;
        load_s      = tick_s & enable_i;
        flush_s     = tick_s & ~enable_i;
        underrun_s  = load_s & ~hold_full_r;
        feed_data_s = hold_full_r ? hold_data_r : last_r;
        feed_live_s = hold_full_r | primed_r;
    end

    dac_scale_sat #(
        .IN_WIDTH (IN_WIDTH)
    ) u_scale (
        .clock_i   (clock_i),
        .reset     (reset),
        .load      (load_s),
        .flush     (flush_s),
        .live      (feed_live_s),
        .sample    (feed_data_s),
        .gain      (gain_i),
        .offset    (offset_i),
        .code      (code_s),
        .sat_pulse (sat_pulse_s)
    );

    // Phase counter, strobe, hold register and output word.
    always_ff @(posedge clock_i) begin
        if (reset) begin
            phase_r     <= '0;
            dclk_n_r    <= 1'b1;
            hold_full_r <= 1'b0;
            hold_data_r <= '0;
            last_r      <= '0;
            primed_r    <= 1'b0;
            data_r      <= DAC_MIDSCALE;
        end else begin
            phase_r <= tick_s ? '0 : phase_r + PHASE_ONE;
            if (tick_s) begin
                dclk_n_r <= 1'b1;
            end else if (phase_r == PHASE_FALL) begin
                dclk_n_r <= 1'b0;
            end else begin
                dclk_n_r <= dclk_n_r;
            end

            if (!enable_i) begin
                hold_full_r <= 1'b0;
                primed_r    <= 1'b0;
            end else begin
                if (load_s && hold_full_r) begin
                    last_r   <= hold_data_r;
                    primed_r <= 1'b1;
                end
                if (accept_s) begin
                    hold_full_r <= 1'b1;
                    hold_data_r <= s_data_i;
                end else if (load_s) begin
                    hold_full_r <= 1'b0;
                end
            end

            if (load_s) begin
                data_r <= code_s;
            end else if (flush_s) begin
                data_r <= DAC_MIDSCALE;
            end
        end
    end

    // Status: a same-edge event beats clear_i.
    always_ff @(posedge clock_i) begin
        if (reset) begin
            underrun_r <= 16'h0000;
            sat_r      <= 1'b0;
        end else begin
            if (clear_i) begin
                underrun_r <= underrun_s ? 16'h0001 : 16'h0000;
                sat_r      <= sat_pulse_s;
            end else begin
                if (underrun_s && (underrun_r != 16'hFFFF)) begin
                    underrun_r <= underrun_r + 16'h0001;
                end
                sat_r <= sat_r | sat_pulse_s;
            end
        end
    end

    assign s_ready_o      = ready_s;
    assign data_o         = data_r;
    assign data_clock_n   = dclk_n_r;
    assign underrun_cnt_o = underrun_r;
    assign sat_o          = sat_r;

endmodule

// File: tb/tb_dac_sample_shaper.sv
// Directed bench for dac_sample_shaper at CLK_DIV=50; edge numbers below count
// rising edges since reset release, so ticks fall on multiples of 50.
module tb_dac_sample_shaper;
    import dac_sample_shaper_pkg::*;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [17:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic [15:0]        gain;
    logic signed [15:0] offset;
    logic               clear;
    logic [15:0]        data;
    logic               dclk_n;
    logic [15:0]        underrun;
    logic               sat;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int acc_cnt;

    dac_sample_shaper #(
        .CLK_DIV  (50),
        .IN_WIDTH (18)
    ) dut (
        .clock_i        (clk),
        .reset          (reset),
        .enable_i       (enable),
        .s_data_i       (s_data),
        .s_valid_i      (s_valid),
        .s_ready_o      (s_ready),
        .gain_i         (gain),
        .offset_i       (offset),
        .clear_i        (clear),
        .data_o         (data),
        .data_clock_n   (dclk_n),
        .underrun_cnt_o (underrun),
        .sat_o          (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic run_to(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic push(input logic signed [17:0] v);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = v;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", {31'd0, (n < 200)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        s_valid = 1'b1;
        s_data  = 18'sd5;
        gain    = DAC_GAIN_ONE;
        offset  = 16'sd0;
        clear   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, s_ready}, 32'd0);
        check("rst_data", {16'd0, data}, 32'h8000);
        check("rst_dclk", {31'd0, dclk_n}, 32'd1);
        check("rst_underrun", {16'd0, underrun}, 32'd0);
        check("rst_sat", {31'd0, sat}, 32'd0);
        s_valid = 1'b0;
        reset   = 1'b0;

        // Free-running after reset with no input
        run_to(24);  check("dclk_pre_fall", {31'd0, dclk_n}, 32'd1);
        run_to(25);  check("dclk_fall25", {31'd0, dclk_n}, 32'd0);
        check("data_fall25", {16'd0, data}, 32'h8000);
        run_to(49);  check("und_pre_tick", {16'd0, underrun}, 32'd0);
        run_to(50);  check("dclk_rise50", {31'd0, dclk_n}, 32'd1);
        check("und_tick50", {16'd0, underrun}, 32'd1);
        check("data_tick50", {16'd0, data}, 32'h8000);

        // Unity gain stream: 0, 1000, -1000
        push(18'sd0);
        push(18'sd1000);
        push(-18'sd1000);
        run_to(175); check("uni_0", {16'd0, data}, 32'h8000);
        run_to(199); check("uni_0_hold", {16'd0, data}, 32'h8000);
        run_to(200); check("uni_1000_tick", {16'd0, data}, 32'h83E8);
        run_to(225); check("uni_1000_fall", {16'd0, data}, 32'h83E8);
        run_to(250); check("uni_m1000", {16'd0, data}, 32'h7C18);
        check("uni_und", {16'd0, underrun}, 32'd2);
        run_to(275); check("uni_m1000_fall", {16'd0, data}, 32'h7C18);

        // Scaling: gain 0.5, offset +100
        gain   = 16'h4000;
        offset = 16'sd100;
        push(18'sd1001);
        push(-18'sd1);
        run_to(375); check("scale_1001", {16'd0, data}, 32'h8258);
        run_to(425); check("scale_m1_floor", {16'd0, data}, 32'h8063);
        check("scale_und", {16'd0, underrun}, 32'd3);
        check("sat_pre", {31'd0, sat}, 32'd0);

        // Saturation at unity gain
        gain   = DAC_GAIN_ONE;
        offset = 16'sd0;
        push(18'sd40000);
        push(-18'sd40000);
        run_to(475); check("sat_set", {31'd0, sat}, 32'd1);
        run_to(525); check("sat_pos", {16'd0, data}, 32'hFFFF);
        run_to(575); check("sat_neg", {16'd0, data}, 32'h0000);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("sat_clear", {31'd0, sat}, 32'd0);
        check("und_clear1", {16'd0, underrun}, 32'd0);

        // Underrun: sample 500 then nothing for three ticks
        push(18'sd500);
        run_to(625); check("sat_stays_clear", {31'd0, sat}, 32'd0);
        run_to(775); check("und_hold_data", {16'd0, data}, 32'h81F4);
        check("und_three", {16'd0, underrun}, 32'd3);
        run_to(799);
        s_valid = 1'b1;
        s_data  = -18'sd2;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        check("und_tick_accept", {16'd0, underrun}, 32'd4);
        run_to(850); check("und_held_sample", {16'd0, underrun}, 32'd4);
        run_to(925); check("tick_accept_data", {16'd0, data}, 32'h7FFE);
        check("und_five", {16'd0, underrun}, 32'd5);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("und_clear2", {16'd0, underrun}, 32'd0);
        run_to(949);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("clear_vs_event", {16'd0, underrun}, 32'd1);

        // Backpressure: valid held high for four periods
        s_valid = 1'b1;
        s_data  = 18'sd7;
        acc_cnt = 0;
        while (edge_cnt < 1150) begin
            if (s_ready) acc_cnt++;
            @(negedge clk);
        end
        check("bp_accepts", acc_cnt, 32'd5);
        check("bp_no_underrun", {16'd0, underrun}, 32'd1);
        run_to(1175); check("bp_data", {16'd0, data}, 32'h8007);

        // Disable during the tick cycle
        run_to(1199); check("bp_tick_ready", {31'd0, s_ready}, 32'd1);
        enable = 1'b0;
        #1;
        check("dis_ready", {31'd0, s_ready}, 32'd0);
        run_to(1200); check("dis_midscale", {16'd0, data}, 32'h8000);
        run_to(1224); check("dis_dclk_hi", {31'd0, dclk_n}, 32'd1);
        run_to(1225); check("dis_dclk_fall", {31'd0, dclk_n}, 32'd0);
        run_to(1250); check("dis_dclk_rise", {31'd0, dclk_n}, 32'd1);
        check("dis_no_underrun", {16'd0, underrun}, 32'd1);

        // Re-enable: midscale until one tick after the first consumed sample
        enable = 1'b1;
        run_to(1325); check("reen_midscale", {16'd0, data}, 32'h8000);
        run_to(1375); check("reen_data", {16'd0, data}, 32'h8007);

        // Reset while the strobe is low
        run_to(1380); check("pre_rst_dclk", {31'd0, dclk_n}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_dclk", {31'd0, dclk_n}, 32'd1);
        check("midrst_data", {16'd0, data}, 32'h8000);
        check("midrst_ready", {31'd0, s_ready}, 32'd0);
        check("midrst_underrun", {16'd0, underrun}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
